// File: rtl/pll_mode_writer.sv
// PLL reconfiguration sequencer: turns N/M/C0 ratios into register writes for the reconfig FIFO.
// Optional build macro PLL_FRAC_EN adds the fractional-K write (W_K) to the sequence.
module pll_mode_writer #(
   parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [8:0]  n_div,
   input  logic [8:0]  m_div,
   input  logic [8:0]  c_div,
   input  logic [31:0] k_frac,
   output logic [5:0]  pll_addr,
   output logic [31:0] pll_value,
   output logic        pll_write,
   input  logic        pll_busy,
   output logic        busy,
   output logic        done,
   output logic        bad_div,
   output logic [3:0]  fsm_state
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] W_MODE  = 4'd1;
   localparam logic [3:0] W_N     = 4'd2;
   localparam logic [3:0] W_M     = 4'd3;
   localparam logic [3:0] W_C     = 4'd4;
`ifdef PLL_FRAC_EN
   localparam logic [3:0] W_K     = 4'd5;
`endif
   localparam logic [3:0] W_START = 4'd6;
   localparam logic [3:0] SETTLE  = 4'd7;
   localparam logic [3:0] DONE    = 4'd8;

   localparam logic [5:0] ADDR_MODE  = 6'd0;
   localparam logic [5:0] ADDR_START = 6'd2;
   localparam logic [5:0] ADDR_N     = 6'd3;
   localparam logic [5:0] ADDR_M     = 6'd4;
   localparam logic [5:0] ADDR_C     = 6'd5;
`ifdef PLL_FRAC_EN
   localparam logic [5:0] ADDR_K     = 6'd7;
`endif

   // Counter-select field [22:18]; 0 addresses C0.
   localparam logic [31:0] C0_SEL = {9'd0, 5'd0, 18'd0};

   // A zero setting still waits one cycle.
   localparam logic [15:0] SETTLE_LOAD = (SETTLE_CYCLES == 16'd0) ? 16'd0 : SETTLE_CYCLES - 16'd1;

   logic [3:0]  state;
   logic [3:0]  nxt;
   logic [8:0]  n_lat;
   logic [8:0]  m_lat;
   logic [8:0]  c_lat;
   logic [15:0] settle_cnt;
   logic        in_w;
   logic [5:0]  addr_d;
   logic [31:0] value_d;

`ifdef PLL_FRAC_EN
   logic [31:0] k_lat;
`else
   logic        unused_k_frac;
   assign unused_k_frac = ^k_frac;
`endif

   // Counter word: high = ceil(d/2), low = floor(d/2), odd flag at 17; d=1 uses bypass.
   function automatic logic [31:0] cnt_word(input logic [8:0] d);
      logic [7:0] high;
      high = d[8:1] + {7'd0, d[0]};
      if (d == 9'd1)
         cnt_word = 32'h0001_0000;
      else
         cnt_word = {14'd0, d[0], 1'b0, high, d[8:1]};
   endfunction

   // Handshake: one word leaves on every cycle pll_write is high; pll_write never rises
   // while pll_busy is high, and pll_addr/pll_value stay put until the word is taken.
   always_comb begin
      in_w = 1'b0;
      case (state)
         W_MODE, W_N, W_M, W_C, W_START: in_w = 1'b1;
`ifdef PLL_FRAC_EN
         W_K:                            in_w = 1'b1;
`endif
         default:                        in_w = 1'b0;
      endcase
   end

   // A rejected request passes through W_MODE without writing.
   assign pll_write = in_w & ~pll_busy & ~((state == W_MODE) & bad_div);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req) nxt = W_MODE;
         W_MODE: begin
            if (bad_div)
               nxt = IDLE;
            else if (pll_write)
               nxt = W_N;
         end
         W_N:     if (pll_write) nxt = W_M;
         W_M:     if (pll_write) nxt = W_C;
`ifdef PLL_FRAC_EN
         W_C:     if (pll_write) nxt = W_K;
         W_K:     if (pll_write) nxt = W_START;
`else
         W_C:     if (pll_write) nxt = W_START;
`endif
         W_START: if (pll_write) nxt = SETTLE;
         SETTLE:  if (settle_cnt == 16'd0) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Word for the state being entered, so the registered outputs line up with it.
   always_comb begin
      addr_d  = '0;
      value_d = '0;
      case (nxt)
         W_MODE: begin
            addr_d  = ADDR_MODE;
            value_d = 32'h0;
         end
         W_N: begin
            addr_d  = ADDR_N;
            value_d = cnt_word(n_lat);
         end
         W_M: begin
            addr_d  = ADDR_M;
            value_d = cnt_word(m_lat);
         end
         W_C: begin
            addr_d  = ADDR_C;
            value_d = cnt_word(c_lat) | C0_SEL;
         end
`ifdef PLL_FRAC_EN
         W_K: begin
            addr_d  = ADDR_K;
            value_d = k_lat;
         end
`endif
         W_START: begin
            addr_d  = ADDR_START;
            value_d = 32'h1;
         end
         default: begin
            addr_d  = '0;
            value_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         n_lat      <= '0;
         m_lat      <= '0;
         c_lat      <= '0;
         bad_div    <= 1'b0;
         settle_cnt <= '0;
         pll_addr   <= '0;
         pll_value  <= '0;
      end else begin
         state     <= nxt;
         pll_addr  <= addr_d;
         pll_value <= value_d;
         if (state == IDLE && req) begin
            n_lat   <= n_div;
            m_lat   <= m_div;
            c_lat   <= c_div;
            bad_div <= (n_div == 9'd0) | (m_div == 9'd0) | (c_div == 9'd0);
         end
         if (state == W_START && pll_write)
            settle_cnt <= SETTLE_LOAD;
         else if (state == SETTLE && settle_cnt != 16'd0)
            settle_cnt <= settle_cnt - 16'd1;
      end
   end

`ifdef PLL_FRAC_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         k_lat <= '0;
      else if (state == IDLE && req)
         k_lat <= k_frac;
   end
`endif

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign fsm_state = state;

   a_no_write_when_full: assert property (@(posedge clk) disable iff (!reset_n)
      pll_busy |-> !pll_write);

   a_word_held: assert property (@(posedge clk) disable iff (!reset_n)
      (in_w && pll_busy) |=> ($stable(pll_addr) && $stable(pll_value)));

   a_done_single: assert property (@(posedge clk) disable iff (!reset_n)
      done |=> !done);

endmodule

// File: tb/tb_pll_mode_writer.sv
// Bench for pll_mode_writer: random ratios and random FIFO back-pressure against a
// sequence-level model (expected word list, write cycles from the busy history, done time).
module tb_pll_mode_writer;

   localparam logic [15:0] S = 16'd4;
`ifdef PLL_FRAC_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif
   localparam logic [37:0] NO_WORD = 38'h3F_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic [8:0]  n_div = '0;
   logic [8:0]  m_div = '0;
   logic [8:0]  c_div = '0;
   logic [31:0] k_frac = '0;
   logic        pll_busy = 1'b0;
   logic [5:0]  pll_addr;
   logic [31:0] pll_value;
   logic        pll_write;
   logic        busy;
   logic        done;
   logic        bad_div;
   logic [3:0]  fsm_state;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          busy_hist [0:65535];
   int          busy_mode = 0;
   int          bs_from = -1;
   int          bs_to = -1;
   logic [37:0] exp_q[$];
   int          req_cyc = -100;
   int          wr_ref = 0;
   int          last_wr_cyc = 0;
   int          exp_done = -1;
   int          n_done = 0;
   int          txn_writes = 0;
   logic [37:0] mon_w;
   logic [37:0] mon_e;
   int          mon_ec;

   pll_mode_writer #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .n_div     (n_div),
      .m_div     (m_div),
      .c_div     (c_div),
      .k_frac    (k_frac),
      .pll_addr  (pll_addr),
      .pll_value (pll_value),
      .pll_write (pll_write),
      .pll_busy  (pll_busy),
      .busy      (busy),
      .done      (done),
      .bad_div   (bad_div),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] cnt_ref(input int d);
      if (d == 1) return 32'h0001_0000;
      return 32'((((d + 1) / 2) << 8) + (d / 2) + ((d % 2) << 17));
   endfunction

   task automatic push_words(input int n, input int m, input int c, input logic [31:0] k);
      exp_q.push_back({6'd0, 32'h0});
      exp_q.push_back({6'd3, cnt_ref(n)});
      exp_q.push_back({6'd4, cnt_ref(m)});
      exp_q.push_back({6'd5, cnt_ref(c)});
`ifdef PLL_FRAC_EN
      exp_q.push_back({6'd7, k});
`else
      if (k == 32'hDEAD_BEEF) exp_q.push_back({6'd0, k});
      if (k == 32'hDEAD_BEEF) void'(exp_q.pop_back());
`endif
      exp_q.push_back({6'd2, 32'h1});
   endtask

   function automatic logic [8:0] pick_ratio();
      case ($urandom_range(0, 5))
         0:       return 9'd1;
         1:       return 9'd2;
         2:       return 9'd256;
         3:       return 9'd255;
         default: return 9'($urandom_range(1, 256));
      endcase
   endfunction

   // ---------------- FIFO back-pressure driver ----------------
   always begin
      @(posedge clk);
      #1;
      case (busy_mode)
         0:       pll_busy = 1'b0;
         1:       pll_busy = ($urandom_range(0, 2) == 0);
         default: pll_busy = (cyc >= bs_from && cyc <= bs_to);
      endcase
      if (cyc < 65536) busy_hist[cyc] = pll_busy;
   end

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         if (pll_busy) check("write_while_full", {63'd0, pll_write}, 64'd0);
         if (pll_busy && exp_q.size() > 0 && cyc > req_cyc)
            check("held_word", {26'd0, pll_addr, pll_value}, {26'd0, exp_q[0]});
         if (pll_write) begin
            mon_w = {pll_addr, pll_value};
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else mon_e = NO_WORD;
            check("write_word", {26'd0, mon_w}, {26'd0, mon_e});
            // Each write lands on the first cycle after the previous one with the FIFO not full.
            mon_ec = wr_ref + 1;
            while (mon_ec < cyc && busy_hist[mon_ec]) mon_ec++;
            check("write_cycle", cyc, mon_ec);
            wr_ref      = cyc;
            last_wr_cyc = cyc;
            txn_writes++;
            if (exp_q.size() == 0) exp_done = cyc + int'(S) + 1;
         end
         if (done) begin
            check("done_cycle", cyc, exp_done);
            check("busy_at_done", {63'd0, busy}, 64'd1);
            exp_done = -1;
            n_done++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c,
                         input logic [31:0] k, input int poke, input int throttle);
      bit bad;
      int d0;
      int t;
      bit poked;
      @(posedge clk);
      #1;
      n_div = n; m_div = m; c_div = c; k_frac = k; req = 1'b1;
      req_cyc = cyc; wr_ref = cyc; exp_done = -1; txn_writes = 0; d0 = n_done;
      if (throttle != 0) begin
         bs_from = cyc + 3;
         bs_to   = cyc + 5;
      end
      bad = (n == 9'd0) || (m == 9'd0) || (c == 9'd0);
      if (!bad) push_words(int'(n), int'(m), int'(c), k);
      @(posedge clk);
      #1;
      req = 1'b0;
      n_div = 9'($urandom); m_div = 9'($urandom); c_div = 9'($urandom); k_frac = $urandom;
      @(negedge clk);
      #1;
      check("busy_after_req", {63'd0, busy}, 64'd1);
      check("bad_div_flag", {63'd0, bad_div}, {63'd0, bad});
      if (bad) begin
         @(negedge clk);
         #1;
         check("busy_bad_pulse", {63'd0, busy}, 64'd0);
         repeat (8) @(negedge clk);
         #1;
         check("bad_no_done", n_done - d0, 0);
         check("bad_no_write", txn_writes, 0);
         check("bad_div_sticky", {63'd0, bad_div}, 64'd1);
      end else begin
         poked = 1'b0;
         t = 0;
         while (n_done == d0 && t < 400) begin
            @(negedge clk);
            #1;
            t++;
            if (poke != 0 && !poked && exp_q.size() == 0 && cyc == last_wr_cyc + 2) begin
               req = 1'b1;
               n_div = pick_ratio(); m_div = pick_ratio(); c_div = pick_ratio();
               poked = 1'b1;
            end else begin
               req = 1'b0;
            end
         end
         req = 1'b0;
         check("done_seen", n_done - d0, 1);
         check("write_count", txn_writes, NW);
         check("bad_div_clear", {63'd0, bad_div}, 64'd0);
         @(negedge clk);
         #1;
         check("busy_after_done", {63'd0, busy}, 64'd0);
         check("done_pulse", {63'd0, done}, 64'd0);
      end
      bs_from = -1;
      bs_to   = -1;
   endtask

   task automatic reset_mid_seq();
      @(posedge clk);
      #1;
      n_div = 9'd5; m_div = 9'd9; c_div = 9'd3; k_frac = $urandom; req = 1'b1;
      req_cyc = cyc; wr_ref = cyc; exp_done = -1; txn_writes = 0;
      push_words(5, 9, 3, k_frac);
      @(posedge clk);
      #1;
      req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("addr_in_w_m", {58'd0, pll_addr}, 64'd4);
      reset_n = 1'b0;
      #1;
      check("rst_mid_write", {63'd0, pll_write}, 64'd0);
      check("rst_mid_addr", {58'd0, pll_addr}, 64'd0);
      check("rst_mid_value", {32'd0, pll_value}, 64'd0);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_done", {63'd0, done}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("rst_writes_before", txn_writes, 2);
      check("rst_idle_busy", {63'd0, busy}, 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_pll_write", {63'd0, pll_write}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_bad_div", {63'd0, bad_div}, 64'd0);
      check("rst_pll_addr", {58'd0, pll_addr}, 64'd0);
      check("rst_pll_value", {32'd0, pll_value}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      busy_mode = 0;
      do_req(9'd1, 9'd40, 9'd7, $urandom, 0, 0);

      busy_mode = 2;
      do_req(9'd3, 9'd40, 9'd7, $urandom, 0, 1);

      busy_mode = 0;
      do_req(9'd5, 9'd256, 9'd2, 32'h8000_0000, 0, 0);

      do_req(9'd0, 9'd10, 9'd10, $urandom, 0, 0);
      do_req(9'd12, 9'd13, 9'd14, $urandom, 0, 0);
      do_req(9'd7, 9'd8, 9'd0, $urandom, 0, 0);
      do_req(9'd256, 9'd1, 9'd255, 32'h8000_0000, 0, 0);

      do_req(9'd6, 9'd33, 9'd4, $urandom, 1, 0);

      reset_mid_seq();
      do_req(9'd9, 9'd17, 9'd2, $urandom, 0, 0);

      busy_mode = 1;
      for (int i = 0; i < 20; i++)
         do_req(pick_ratio(), pick_ratio(), pick_ratio(), $urandom, (i % 4 == 0) ? 1 : 0, 0);

      busy_mode = 0;
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pll_mode_writer.md
# pll_mode_writer

Upstream feeder for the clk_sys-side write port of the PLL-reconfiguration FIFO. On a mode request it converts the requested N, M and C0 divide ratios into PLL reconfiguration register words. It issues the fixed register-write sequence (mode, N, M, C0, optional fractional K, start) as single-cycle FIFO writes, throttled by the FIFO full flag. It then waits a settle interval and pulses `done`, so the video timing generator knows when the pixel clock has stabilised.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16'd50000: clk cycles to wait after the start write before `done`.

Ports:
- `clk`  in  1  clk_sys domain clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  single-cycle mode-change request; sampled only in IDLE.
- `n_div`  in  9  N divide ratio, 1..256. Latched on accepted `req`.
- `m_div`  in  9  M divide ratio, 1..256. Latched on accepted `req`.
- `c_div`  in  9  C0 divide ratio, 1..256. Latched on accepted `req`.
- `k_frac`  in  32  fractional M value. Latched on accepted `req`; used only with PLL_FRAC_EN.
- `pll_addr`  out  6  register address of the current write.
- `pll_value`  out  32  register data of the current write.
- `pll_write`  out  1  FIFO write strobe; one word consumed per cycle high.
- `pll_busy`  in  1  FIFO write-side full flag.
- `busy`  out  1  high from accepted `req` until the `done` cycle inclusive.
- `done`  out  1  one-cycle pulse at the end of the settle wait.
- `bad_div`  out  1  sticky: a request contained a ratio of 0. Cleared by the next accepted `req`.

## Operation
- States, in order: IDLE, W_MODE, W_N, W_M, W_C, W_K (present only with PLL_FRAC_EN), W_START, SETTLE, DONE.
- In IDLE, `req`=1 does three things: it latches all ratio inputs, sets `busy`, and enters W_MODE.
  - If any latched ratio is 0, the block sets `bad_div`, returns to IDLE and issues no writes. `busy` pulses for 1 cycle and `done` is not asserted.
- `req` outside IDLE is ignored. It is not queued.
- Every W_* state presents a fixed address and value, shown below. `pll_write = ~pll_busy` while in a W_* state and 0 otherwise. On the cycle `pll_write`=1 the FSM advances to the next state. The block holds the state while `pll_busy`=1.
  - W_MODE: addr 0, data 32'h0 (waitrequest mode).
  - W_N: addr 3, data = cnt(n_div).
  - W_M: addr 4, data = cnt(m_div).
  - W_C: addr 5, data = cnt(c_div) | (5'd0 << 18), which selects counter C0.
  - W_K: addr 7, data = k_frac.
  - W_START: addr 2, data 32'h1.
- cnt(d) encodes as follows:
  - For d=1: 32'h0001_0000, which sets bypass bit 16 with high=low=0.
  - For d≥2: high[15:8] = ceil(d/2), low[7:0] = floor(d/2), odd[17] = d[0], bypass = 0.
  - For d=256: high=low=128.
  - Bits [31:23] are always 0.
- SETTLE: a 16-bit down-counter is loaded with SETTLE_CYCLES−1 on entry. The FSM moves to DONE when the counter reaches 0. With SETTLE_CYCLES=0 the block behaves as 1.
- DONE: `done`=1 for one cycle, `busy` deasserts on the following cycle, and the FSM returns to IDLE.
- Reset mid-sequence abandons the sequence. Words already in the FIFO are not retracted, and no recovery writes are issued.

## Timing
- Reset values: `pll_write`=0, `busy`=0, `done`=0, `bad_div`=0, `pll_addr`=0, `pll_value`=0, state=IDLE, settle counter=0.
- `pll_addr` and `pll_value` are registered. They are valid and stable for the entire time a W_* state is held.
- `pll_write` is combinational from state and `pll_busy`. Unthrottled writes occur on back-to-back cycles.
- Latency with `pll_busy`=0 throughout: the first `pll_write` comes 1 cycle after `req`. The last write (W_START) comes at `req`+5 without the macro, or `req`+6 with it. `done` comes SETTLE_CYCLES+1 cycles after the W_START write.
- If `pll_busy` rises in the same cycle the FSM enters a W_* state, no write is issued that cycle.

## Configuration
- `PLL_FRAC_EN` defined: W_K is part of the sequence, 6 writes in total, and `k_frac` is latched.
- `PLL_FRAC_EN` undefined: W_K is removed, W_C goes directly to W_START, 5 writes in total. `k_frac` is unused and its latch is not synthesised.

## Test plan
- Basic sequence, no macro: n=1, m=40, c=7, `pll_busy`=0, SETTLE_CYCLES=4. Required:
  - writes (0,0), (3,0001_0000), (4,0000_1414), (5,0002_0403), (2,1) on consecutive cycles;
  - `done` 5 cycles after the last write.
- Throttling: hold `pll_busy`=1 for 3 cycles while in W_M. Required: `pll_addr`=4 is held, `pll_write`=0 for those 3 cycles, the M write occurs on the 4th cycle, and all words are unchanged.
- Fractional build (PLL_FRAC_EN): k_frac=32'h8000_0000. Required: a write (7,8000_0000) between the C0 and start writes, 6 writes in total.
- Ratio edge cases:
  - m=256 gives 0000_8080.
  - c=2 gives 0000_0101.
  - n=0 gives `bad_div`=1, no `pll_write`, and no `done`.
  - A following valid `req` clears `bad_div`.
- `req` during SETTLE: ignored, no extra writes, and `done` stays at its original cycle.
- Assert `reset_n` low during W_M: all outputs return to 0 asynchronously. After release, the next `req` restarts from W_MODE.
